// File: rtl/qpsk_fsync_pkg.sv
// qpsk_fsync_pkg: shared state enum, dibit width, default sync word and Gray dibit rotation helpers.
package qpsk_fsync_pkg;
  localparam int DIBIT_W = 2;
  localparam logic [15:0] SYNC_DEFAULT = 16'h1ACF;
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_e;
  function automatic logic [DIBIT_W-1:0] rot(input logic [DIBIT_W-1:0] d);
    return {d[0], ~d[1]};
  endfunction
  function automatic logic [DIBIT_W-1:0] rot_inv(input logic [DIBIT_W-1:0] d);
    return {~d[0], d[1]};
  endfunction
  function automatic logic [DIBIT_W-1:0] swap(input logic [DIBIT_W-1:0] d);
    return {d[0], d[1]};
  endfunction
endpackage

// File: rtl/qpsk_frame_sync_if.sv
// qpsk_frame_sync_if: demodulated dibit stream in, de-rotated byte stream and lock status out.
interface qpsk_frame_sync_if;
  import qpsk_fsync_pkg::*;
  logic [DIBIT_W-1:0] qpsk;
  logic               vld;
  logic [7:0]         data;
  logic               data_vld;
  logic               frame_start;
  logic               locked;
  logic [1:0]         phase;
  logic               conj;
  modport master (output qpsk, vld, input data, data_vld, frame_start, locked, phase, conj);
  modport slave (input qpsk, vld, output data, data_vld, frame_start, locked, phase, conj);
endinterface

// File: rtl/qpsk_dibit_rotate.sv
// qpsk_dibit_rotate: optional bit swap followed by k quarter-turn Gray rotations of one dibit.
module qpsk_dibit_rotate
  import qpsk_fsync_pkg::*;
(
  input  logic [DIBIT_W-1:0] d_i,
  input  logic [1:0]         k_i,
  input  logic               conj_i,
  output logic [DIBIT_W-1:0] d_o
);
  logic [DIBIT_W-1:0] s;
  assign s = conj_i ? swap(d_i) : d_i;
  assign d_o = k_i == 2'd0 ? s : k_i == 2'd1 ? rot(s) : k_i == 2'd2 ? rot(rot(s)) : rot_inv(s);
endmodule

// File: rtl/qpsk_frame_sync.sv
// qpsk_frame_sync: sync-word hunt over all QPSK rotations, flywheel lock and payload byte de-rotation.
// Define QPSK_FSYNC_CONJ_EN to also hunt the bit-swapped (conjugate) constellation variants.
module qpsk_frame_sync
  import qpsk_fsync_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD     = SYNC_DEFAULT,
  parameter int          PAYLOAD_BYTES = 16,
  parameter int          MISS_MAX      = 2
) (
  input  logic               clk_16M384,
  input  logic               rst_16M384,
  qpsk_frame_sync_if.slave   bus
);
`ifdef QPSK_FSYNC_CONJ_EN
  localparam int NC = 2;
`else
  localparam int NC = 1;
`endif
  state_e             state_q;
  logic [15:0]        win_q, win_d;
  logic [2:0]         dcnt_q, miss_q;
  logic [7:0]         bcnt_q, data_q;
  logic [5:0]         sh_q;
  logic               first_q, data_vld_q, fs_q, locked_q, conj_q;
  logic [1:0]         phase_q, k_pay, hit_k;
  logic               hit, hit_c, sync_ok;
  logic [DIBIT_W-1:0] pd;
  logic [NC-1:0][3:0][15:0] cand;
  assign win_d = {win_q[13:0], bus.qpsk};
  genvar c, k, i;
  for (c = 0; c < NC; c++) begin : g_c
    for (k = 0; k < 4; k++) begin : g_k
      for (i = 0; i < 8; i++) begin : g_i
        qpsk_dibit_rotate u_cand (
          .d_i(SYNC_WORD[2*i +: 2]), .k_i(2'(k)), .conj_i(1'(c)), .d_o(cand[c][k][2*i +: 2])
        );
      end
    end
  end
  // lowest k wins; at equal k the plain variant beats the conjugate one
  always_comb begin
    hit = 1'b0;
    hit_k = 2'd0;
    hit_c = 1'b0;
    for (int n = 3; n >= 0; n--)
      for (int m = NC - 1; m >= 0; m--)
        if (win_d == cand[m][n]) begin
          hit = 1'b1;
          hit_k = 2'(n);
          hit_c = 1'(m);
        end
  end
`ifdef QPSK_FSYNC_CONJ_EN
  assign sync_ok = win_d == cand[conj_q][phase_q];
`else
  assign sync_ok = win_d == cand[0][phase_q];
`endif
  // the conjugate variant is an involution, so its inverse reuses the same k
  assign k_pay = conj_q ? phase_q : 2'd0 - phase_q;
  qpsk_dibit_rotate u_pay (.d_i(bus.qpsk), .k_i(k_pay), .conj_i(conj_q), .d_o(pd));
  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      state_q <= HUNT;
      win_q <= '0;
      dcnt_q <= '0;
      bcnt_q <= '0;
      miss_q <= '0;
      sh_q <= '0;
      first_q <= 1'b0;
      data_q <= '0;
      data_vld_q <= 1'b0;
      fs_q <= 1'b0;
      locked_q <= 1'b0;
      phase_q <= '0;
      conj_q <= 1'b0;
    end else begin
      data_vld_q <= 1'b0;
      fs_q <= 1'b0;
      if (bus.vld) begin
        win_q <= win_d;
        case (state_q)
          HUNT: if (hit) begin
            state_q <= PAYLOAD;
            phase_q <= hit_k;
            conj_q <= hit_c;
            locked_q <= 1'b1;
            miss_q <= '0;
            dcnt_q <= '0;
            bcnt_q <= '0;
            first_q <= 1'b1;
          end
          PAYLOAD: begin
            sh_q <= {sh_q[3:0], pd};
            dcnt_q <= dcnt_q + 3'd1;
            if (dcnt_q[1:0] == 2'd3) begin
              dcnt_q <= '0;
              data_q <= {sh_q, pd};
              data_vld_q <= 1'b1;
              fs_q <= first_q;
              first_q <= 1'b0;
              bcnt_q <= bcnt_q + 8'd1;
              if (bcnt_q == 8'(PAYLOAD_BYTES - 1)) begin
                bcnt_q <= '0;
                state_q <= CHECK;
              end
            end
          end
          CHECK: begin
            dcnt_q <= dcnt_q + 3'd1;
            if (dcnt_q == 3'd7) begin
              dcnt_q <= '0;
              first_q <= 1'b1;
              state_q <= PAYLOAD;
              if (sync_ok) miss_q <= '0;
              else begin
                miss_q <= miss_q + 3'd1;
                if (miss_q + 3'd1 >= 3'(MISS_MAX)) begin
                  state_q <= HUNT;
                  locked_q <= 1'b0;
                end
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end
  assign bus.data = data_q;
  assign bus.data_vld = data_vld_q;
  assign bus.frame_start = fs_q;
  assign bus.locked = locked_q;
  assign bus.phase = phase_q;
  assign bus.conj = conj_q;
endmodule

// File: tb/tb_qpsk_frame_sync.sv
// tb_qpsk_frame_sync: randomized streams checked against a frame-level model of the sync rules.
module tb_qpsk_frame_sync;
  import qpsk_fsync_pkg::*;
  localparam int N = 16;
  localparam int MM = 2;
`ifdef QPSK_FSYNC_CONJ_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif
  typedef struct {logic [7:0] b; logic fs; int idx;} exp_t;
  typedef struct {logic [7:0] b; logic fs; int cyc;} obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int fall_cyc = -1;
  logic prev_lk = 1'b0;
  obs_t obs[$];
  int vcyc[$];
  logic [1:0] stim[$];
  logic [1:0] r_tbl [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
  logic [15:0] sync_w = 16'h1ACF;
  always #5 clk = ~clk;
  qpsk_frame_sync_if bus();
  qpsk_frame_sync dut (.clk_16M384(clk), .rst_16M384(rst), .bus(bus));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.data_vld) obs.push_back('{bus.data, bus.frame_start, cyc});
    else if (bus.frame_start) obs.push_back('{bus.data, 1'b1, -1});
    if (!prev_lk && bus.locked && rise_cyc < 0) rise_cyc <= cyc;
    if (prev_lk && !bus.locked) fall_cyc <= cyc;
    prev_lk <= bus.locked;
  end
  function automatic logic [1:0] tx(input logic [1:0] x, input logic [1:0] k, input logic c);
    logic [1:0] y;
    y = c ? {x[0], x[1]} : x;
    for (int j = 0; j < int'(k); j++) y = r_tbl[y];
    return y;
  endfunction
  function automatic logic [1:0] derot(input logic [1:0] rx, input logic [1:0] k, input logic c);
    logic [1:0] r = 2'b00;
    for (int x = 0; x < 4; x++) if (tx(2'(x), k, c) == rx) r = 2'(x);
    return r;
  endfunction
  function automatic logic [15:0] variant(input logic [1:0] k, input logic c);
    logic [15:0] v = '0;
    for (int j = 0; j < 8; j++) v[15-2*j -: 2] = tx(sync_w[15-2*j -: 2], k, c);
    return v;
  endfunction
  function automatic logic [15:0] win_at(input int i);
    logic [15:0] w = '0;
    for (int j = i - 7; j <= i; j++) w = {w[13:0], (j >= 0) ? stim[j] : 2'b00};
    return w;
  endfunction
  function automatic logic [7:0] unpack(input int p, input logic [1:0] k, input logic c);
    return {derot(stim[p], k, c), derot(stim[p+1], k, c), derot(stim[p+2], k, c), derot(stim[p+3], k, c)};
  endfunction
  task automatic add_sync(input logic [1:0] k, input logic c, input logic corrupt);
    logic [1:0] d;
    for (int j = 0; j < 8; j++) begin
      d = tx(sync_w[15-2*j -: 2], k, c);
      if (corrupt && j == 3) d = d ^ 2'b01;
      stim.push_back(d);
    end
  endtask
  task automatic add_byte(input logic [7:0] b, input logic [1:0] k, input logic c);
    for (int j = 0; j < 4; j++) stim.push_back(tx(b[7-2*j -: 2], k, c));
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, x);
    end
  endtask
  task automatic drive(input logic [1:0] d, input int gap);
    vcyc.push_back(cyc);
    bus.qpsk = d;
    bus.vld = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    bus.qpsk = 2'($urandom);
    repeat (gap) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  // frame-level view: find the sync, slice N-byte frames and 8-dibit checks, apply the miss rule
  task automatic model(output exp_t e[$], output logic lk, output logic [1:0] ph, output logic cj,
                       output int rise, output int fall);
    int n, i, pos, miss;
    logic found, done;
    n = stim.size();
    i = 0;
    e = {};
    lk = 1'b0;
    ph = 2'd0;
    cj = 1'b0;
    rise = -1;
    fall = -1;
    while (i < n) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++)
        for (int c = 0; c <= CE; c++)
          if (!found && win_at(i) == variant(2'(k), c[0])) begin
            found = 1'b1;
            ph = 2'(k);
            cj = c[0];
          end
      if (!found) i++;
      else begin
        lk = 1'b1;
        if (rise < 0) rise = i;
        miss = 0;
        pos = i + 1;
        done = 1'b0;
        while (!done) begin
          for (int b = 0; b < N && !done; b++)
            if (pos + 4*b + 3 >= n) done = 1'b1;
            else e.push_back('{unpack(pos + 4*b, ph, cj), b == 0, pos + 4*b + 3});
          if (!done) begin
            pos += 4*N;
            if (pos + 7 >= n) done = 1'b1;
            else begin
              miss = (win_at(pos + 7) == variant(ph, cj)) ? 0 : miss + 1;
              pos += 8;
              if (miss >= MM) begin
                lk = 1'b0;
                fall = pos - 1;
                done = 1'b1;
              end
            end
          end
        end
        i = lk ? n : pos;
      end
    end
  endtask
  task automatic run_check(input string tag, input int maxgap);
    exp_t e[$];
    logic lk, cj;
    logic [1:0] ph;
    int rise, fall;
    obs = {};
    vcyc = {};
    rise_cyc = -1;
    fall_cyc = -1;
    foreach (stim[j]) drive(stim[j], int'($urandom_range(maxgap, 0)));
    repeat (4) @(negedge clk);
    model(e, lk, ph, cj, rise, fall);
    chk({tag, ".count"}, obs.size(), e.size());
    for (int j = 0; j < e.size() && j < obs.size(); j++) begin
      chk($sformatf("%s.byte%0d", tag, j), obs[j].b, e[j].b);
      chk($sformatf("%s.fs%0d", tag, j), obs[j].fs, e[j].fs);
      chk($sformatf("%s.lat%0d", tag, j), obs[j].cyc, vcyc[e[j].idx] + 1);
    end
    chk({tag, ".locked"}, bus.locked, lk);
    if (lk) begin
      chk({tag, ".phase"}, bus.phase, ph);
      chk({tag, ".conj"}, bus.conj, cj);
    end
    if (rise >= 0) chk({tag, ".rise"}, rise_cyc, vcyc[rise] + 1);
    if (fall >= 0) chk({tag, ".fall"}, fall_cyc, vcyc[fall] + 1);
  endtask
  initial begin
    logic [1:0] kr;
    bus.qpsk = 2'b00;
    bus.vld = 1'b0;
    do_reset();
    chk("rst.data", bus.data, 0);
    chk("rst.data_vld", bus.data_vld, 0);
    chk("rst.frame_start", bus.frame_start, 0);
    chk("rst.locked", bus.locked, 0);
    chk("rst.phase", bus.phase, 0);
    chk("rst.conj", bus.conj, 0);
    stim = {};
    add_sync(2'd0, 1'b0, 1'b0);
    for (int b = 0; b < 16; b++) add_byte(8'(b), 2'd0, 1'b0);
    add_sync(2'd0, 1'b0, 1'b0);
    for (int b = 0; b < 16; b++) add_byte(8'($urandom), 2'd0, 1'b0);
    run_check("k0", 0);
    do_reset();
    run_check("k0gap", 31);
    do_reset();
    stim = {};
    add_sync(2'd2, 1'b0, 1'b0);
    for (int b = 0; b < 16; b++) add_byte(8'(b), 2'd2, 1'b0);
    run_check("k2", 0);
    do_reset();
    kr = 2'($urandom);
    stim = {};
    add_sync(kr, 1'b0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 16; b++) add_byte(8'($urandom), kr, 1'b0);
      add_sync(kr, 1'b0, f != 1);
    end
    run_check("miss", 3);
    do_reset();
    stim = {};
    add_sync(2'd2, 1'b0, 1'b0);
    for (int b = 0; b < 6; b++) add_byte(8'(b), 2'd2, 1'b0);
    void'(stim.pop_back());
    void'(stim.pop_back());
    foreach (stim[j]) drive(stim[j], 0);
    do_reset();
    chk("midrst.data", bus.data, 0);
    chk("midrst.data_vld", bus.data_vld, 0);
    chk("midrst.locked", bus.locked, 0);
    chk("midrst.phase", bus.phase, 0);
    chk("midrst.state", dut.state_q, HUNT);
    stim = {};
    add_sync(2'd0, 1'b0, 1'b0);
    for (int b = 0; b < 16; b++) add_byte(8'(b), 2'd0, 1'b0);
    run_check("relock", 0);
    do_reset();
    stim = {};
    add_sync(2'd0, 1'b1, 1'b0);
    for (int b = 0; b < 16; b++) add_byte(8'(b), 2'd0, 1'b1);
    run_check("conj", 0);
    do_reset();
    kr = 2'($urandom);
    stim = {};
    for (int b = 0; b < 3; b++) stim.push_back(2'($urandom));
    add_sync(kr, 1'b0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 16; b++) add_byte(8'($urandom), kr, 1'b0);
      add_sync(kr, 1'b0, 1'b0);
    end
    run_check("rand", 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/qpsk_frame_sync.md
QPSK_FRAME_SYNC -- requirements
Module: qpsk_frame_sync

Interface
REQ-001 Parameter SYNC_WORD, default 16'h1ACF: unique word of 8 dibits, first transmitted dibit = bits [15:14].
REQ-002 Parameter PAYLOAD_BYTES, default 16: payload bytes between consecutive sync words, range 1..255.
REQ-003 Parameter MISS_MAX, default 2: consecutive missed sync words tolerated before unlock, range 1..7.
REQ-004 clk_16M384  input  1  sole clock; all logic rising-edge.
REQ-005 rst_16M384  input  1  synchronous, active-high reset.
REQ-006 qpsk  input  2  demodulated dibit from the Rx demodulator; bit1 is the first bit in time.
REQ-007 vld  input  1  qpsk valid strobe; arbitrary gaps permitted.
REQ-008 data  output  8  de-rotated payload byte.
REQ-009 data_vld  output  1  one-cycle strobe per payload byte.
REQ-010 frame_start  output  1  one-cycle strobe coincident with the first payload byte of each frame.
REQ-011 locked  output  1  high while in PAYLOAD or CHECK.
REQ-012 phase  output  2  locked rotation index k (0..3).
REQ-013 conj  output  1  locked conjugate flag (see Configuration).

Function
REQ-014 Rotation R (90 deg, Gray): 00->01, 01->11, 11->10, 10->00; R^k is R applied k times; inverse applied to payload.
REQ-015 Window: 16-bit shift register of the last 8 dibits, shifted only on vld.
REQ-016 States: HUNT, PAYLOAD, CHECK; reset state HUNT.
REQ-017 HUNT: on each vld, compare the updated window against R^k(SYNC_WORD) for k=0..3; a match latches k into phase, enters PAYLOAD, clears the miss counter.
REQ-018 Multiple simultaneous candidate matches: lowest k wins (conj=0 candidates before conj=1).
REQ-019 PAYLOAD: each vld de-rotates the dibit by R^-k and packs it MSB-first (first dibit -> data[7:6]); the 4th dibit asserts data_vld the next cycle.
REQ-020 Latency: data_vld is registered, one cycle after the vld of the byte's 4th dibit.
REQ-021 After PAYLOAD_BYTES bytes, enter CHECK with the dibit counter cleared.
REQ-022 CHECK: collect 8 dibits; compare only against the locked variant; match -> PAYLOAD, miss counter cleared; miss -> miss counter +1, PAYLOAD if the counter remains < MISS_MAX (flywheel), else HUNT with locked low the next cycle.
REQ-023 HUNT never outputs data_vld; CHECK dibits are never output as data.
REQ-024 frame_start is asserted with the first data_vld after every entry to PAYLOAD.
REQ-025 When vld is low, all counters, shift registers and state hold.

Reset
REQ-026 Reset forces data=0, data_vld=0, frame_start=0, locked=0, phase=0, conj=0, window=0, all counters=0, state=HUNT.
REQ-027 Reset mid-frame discards the partial byte; the first cycle after reset is a normal HUNT cycle.

Configuration
REQ-028 Macro QPSK_FSYNC_CONJ_EN defined: HUNT additionally checks the 4 conjugate variants (dibit bits swapped, then R^k); a conjugate match sets conj=1 and payload dibits are un-swapped after de-rotation.
REQ-029 Macro undefined: only 4 candidates are checked; conj is constant 0.

Structure
REQ-030 Package qpsk_fsync_pkg holds the state enum, the dibit width constant, the default sync word, and the R / R^-1 / swap functions.
REQ-031 Sub-module qpsk_dibit_rotate (combinational dibit, k, conj -> dibit) is instantiated for the payload path and for candidate generation.

Verification
REQ-032 Sync 16'h1ACF, then 64 dibits of payload bytes 0x00..0x0F, k=0 -> locked rises; 16 data_vld with data 0x00..0x0F; frame_start on the first byte; phase=0.
REQ-033 Same stream with every dibit rotated by R^2 -> phase=2; identical output bytes 0x00..0x0F.
REQ-034 Lock, then corrupt one sync word with MISS_MAX=2 -> locked stays high; next frame bytes are output; two consecutive corrupt syncs -> locked low after the 2nd CHECK.
REQ-035 Random vld gaps (0..31 idle cycles) on the REQ-032 stream -> identical byte sequence; each data_vld lands exactly 1 cycle after the vld of the byte's 4th dibit.
REQ-036 Reset asserted after 2 dibits of byte 5 -> all outputs 0, state HUNT; a fresh sync relocks and byte 0x00 appears first.
REQ-037 With QPSK_FSYNC_CONJ_EN, a bit-swapped stream -> conj=1, phase=0, bytes 0x00..0x0F; without the macro the same stream -> no lock.
